// File: rtl/riscv_pipe_pkg.sv
// Shared types for the RV32 5-stage pipeline hazard/forwarding control.
package riscv_pipe_pkg;
  localparam int RV_REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10,
    DRAIN    = 2'b11
  } hz_state_e;
endpackage

// File: rtl/forward_unit.sv
// EX operand bypass select: MEM result wins over WB result; x0 never forwards.
module forward_unit
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = RV_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  output fwd_sel_e              sel
);
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && mem_rd != '0 && mem_rd == rs)
      sel = FWD_MEM;
    else if (wb_regwrite && wb_rd != '0 && wb_rd == rs)
      sel = FWD_WB;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for IF/ID/EX/MEM/WB with load-use bubbles,
// branch redirect and data-memory wait, plus saturating perf counters.
module pipe_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int REG_ADDR_W   = RV_REG_ADDR_W,
  parameter int LOAD_LATENCY = 1,
  parameter int BR_IN_MEM    = 0,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rs1,
  input  logic [REG_ADDR_W-1:0] ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_regwrite,
  input  logic                  branch_taken,
  input  logic                  mem_busy,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  stall_E,
  output logic                  stall_M,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic                  flush_M,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [1:0]            hz_state,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam logic [1:0]       LU_EXTRA = 2'(LOAD_LATENCY - 1);
  localparam logic             BR_M     = (BR_IN_MEM != 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  hz_state_e  state, nxt;
  logic [1:0] bub_cnt, bub_nxt;
  logic       lu, br_flush;
  fwd_sel_e   sel_a, sel_b;

  // A load always writes its rd, so memread alone qualifies the hazard.
  logic unused_ctrl;
  assign unused_ctrl = ex_regwrite;

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
  );
  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
  );

  assign fwd_a    = rst ? FWD_RF : sel_a;
  assign fwd_b    = rst ? FWD_RF : sel_b;
  assign hz_state = state;

  assign lu = ex_memread && ex_rd != '0 &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    nxt      = state;
    bub_nxt  = bub_cnt;
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    stall_E  = 1'b0;
    stall_M  = 1'b0;
    flush_D  = 1'b0;
    flush_E  = 1'b0;
    flush_M  = 1'b0;
    br_flush = 1'b0;
    if (!rst) begin
      case (state)
        RUN, LU_STALL: begin
          if (mem_busy) begin
            {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
            nxt = MEM_WAIT;
          end else if (branch_taken) begin
            flush_D  = 1'b1;
            flush_E  = 1'b1;
            flush_M  = BR_M;
            br_flush = 1'b1;
            bub_nxt  = 2'd0;
            nxt      = RUN;
          end else if (state == LU_STALL) begin
            // ID is held here, so lu is not re-evaluated until RUN resumes.
            {stall_F, stall_D, flush_E} = 3'b111;
            if (bub_cnt <= 2'd1) begin
              bub_nxt = 2'd0;
              nxt     = RUN;
            end else begin
              bub_nxt = bub_cnt - 2'd1;
            end
          end else if (lu) begin
            {stall_F, stall_D, flush_E} = 3'b111;
            if (LOAD_LATENCY > 1) begin
              bub_nxt = LU_EXTRA;
              nxt     = LU_STALL;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_busy) {stall_F, stall_D, stall_E, stall_M} = 4'b1111;
          else          nxt = (bub_cnt != 2'd0) ? LU_STALL : RUN;
        end
        default: begin
          bub_nxt = 2'd0;
          nxt     = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      bub_cnt   <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state   <= nxt;
      bub_cnt <= bub_nxt;
      if (stall_F && stall_cnt != '1)  stall_cnt <= stall_cnt + CNT_ONE;
      if (br_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: shared stimulus drives LL=1, LL=3, LL=3/branch-in-MEM and 4-bit-counter variants.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
  logic       mem_regwrite, wb_regwrite, branch_taken, mem_busy;

  logic        sF[4], sD[4], sE[4], sM[4], fD[4], fE[4], fM[4];
  logic [1:0]  fa[4], fb[4], hz[4];
  logic [31:0] scnt[3], fcnt[3];
  logic [3:0]  scnt4, fcnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_hazard_ctrl #(
      .REG_ADDR_W(5), .LOAD_LATENCY(g == 0 ? 1 : 3), .BR_IN_MEM(g == 2 ? 1 : 0), .CNT_W(32)
    ) u_dut (
      .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
      .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .branch_taken(branch_taken), .mem_busy(mem_busy),
      .stall_F(sF[g]), .stall_D(sD[g]), .stall_E(sE[g]), .stall_M(sM[g]),
      .flush_D(fD[g]), .flush_E(fE[g]), .flush_M(fM[g]),
      .fwd_a(fa[g]), .fwd_b(fb[g]), .hz_state(hz[g]),
      .stall_cnt(scnt[g]), .flush_cnt(fcnt[g])
    );
  end

  pipe_hazard_ctrl #(
    .REG_ADDR_W(5), .LOAD_LATENCY(1), .BR_IN_MEM(0), .CNT_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .stall_F(sF[3]), .stall_D(sD[3]), .stall_E(sE[3]), .stall_M(sM[3]),
    .flush_D(fD[3]), .flush_E(fE[3]), .flush_M(fM[3]),
    .fwd_a(fa[3]), .fwd_b(fb[3]), .hz_state(hz[3]),
    .stall_cnt(scnt4), .flush_cnt(fcnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread} = '0;
    {mem_regwrite, wb_regwrite, branch_taken, mem_busy} = '0;
  endtask

  // lw x5 in EX, add x6,x5,x2 in ID
  task automatic set_lu();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
    id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd2; id_use_rs2 = 1'b1;
  endtask

  // EX becomes the bubble injected by flush_E
  task automatic clr_lu();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    set_lu();
    ex_rs1 = 5'd7; mem_rd = 5'd7; mem_regwrite = 1'b1;
    #1;
    chk("rst_stall_F", 32'(sF[1]), 0);
    chk("rst_flush_E", 32'(fE[0]), 0);
    chk("rst_fwd_a", 32'(fa[0]), 0);
    tick(); tick();
    chk("rst_state", 32'(hz[1]), 0);
    chk("rst_stall_cnt", scnt[1], 0);
    idle();
    rst = 1'b0;
    tick();

    // load-use, latency 1 and 3
    set_lu(); #1;
    chk("lu1_stall_F", 32'(sF[0]), 1);
    chk("lu1_stall_D", 32'(sD[0]), 1);
    chk("lu1_flush_E", 32'(fE[0]), 1);
    chk("lu1_stall_E", 32'(sE[0]), 0);
    tick(); clr_lu(); #1;
    chk("lu1_release", 32'(sF[0]), 0);
    chk("lu1_stall_cnt", scnt[0], 1);
    chk("lu3_state_c2", 32'(hz[1]), 1);
    chk("lu3_stall_c2", 32'(sF[1]), 1);
    tick();
    chk("lu3_state_c3", 32'(hz[1]), 1);
    chk("lu3_stall_c3", 32'(fE[1]), 1);
    tick();
    chk("lu3_state_run", 32'(hz[1]), 0);
    chk("lu3_release", 32'(sF[1]), 0);
    chk("lu3_stall_cnt", scnt[1], 3);

    // x0 never causes a load-use stall
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
    chk("x0_no_lu", 32'(sF[0]), 0);
    idle(); #1;

    // forwarding priority
    ex_rs1 = 5'd7; ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7;
    mem_regwrite = 1'b1; wb_regwrite = 1'b1; #1;
    chk("fwd_a_mem", 32'(fa[0]), 2);
    chk("fwd_b_mem", 32'(fb[0]), 2);
    mem_regwrite = 1'b0; #1;
    chk("fwd_a_wb", 32'(fa[0]), 1);
    ex_rs2 = 5'd3; #1;
    chk("fwd_b_none", 32'(fb[0]), 0);
    ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1; #1;
    chk("fwd_a_x0", 32'(fa[0]), 0);
    idle(); #1;

    // branch in cycle 2 of LU_STALL
    set_lu(); tick(); clr_lu();
    branch_taken = 1'b1; #1;
    chk("br_flush_D", 32'(fD[1]), 1);
    chk("br_flush_E", 32'(fE[1]), 1);
    chk("br_stall_F", 32'(sF[1]), 0);
    chk("br_flush_M_ex", 32'(fM[1]), 0);
    chk("br_flush_M_mem", 32'(fM[2]), 1);
    tick(); branch_taken = 1'b0; #1;
    chk("br_state_run", 32'(hz[1]), 0);
    chk("br_flush_cnt", fcnt[1], 1);
    chk("br_flush_cnt_m", fcnt[2], 1);
    chk("br_stall_cnt", scnt[1], 4);
    chk("br_run_flush_cnt", fcnt[0], 1);

    // mem wait while one LU bubble remains
    set_lu(); tick(); clr_lu(); tick();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mw_stall_E", 32'(sE[1]), 1);
      chk("mw_stall_M", 32'(sM[1]), 1);
      chk("mw_no_flush", 32'(fE[1]), 0);
      tick();
      chk("mw_state", 32'(hz[1]), 2);
    end
    mem_busy = 1'b0; #1;
    chk("mw_exit_nostall", 32'(sF[1]), 0);
    tick();
    chk("mw_resume_state", 32'(hz[1]), 1);
    chk("mw_resume_bubble", 32'(fE[1]), 1);
    tick();
    chk("mw_run", 32'(hz[1]), 0);
    chk("mw_stall_cnt", scnt[1], 11);

    // reset in the middle of LU_STALL
    set_lu(); tick(); clr_lu(); #1;
    chk("rst_mid_state_pre", 32'(hz[1]), 1);
    rst = 1'b1; #1;
    chk("rst_mid_stall_F", 32'(sF[1]), 0);
    chk("rst_mid_flush_E", 32'(fE[1]), 0);
    tick(); rst = 1'b0; #1;
    chk("rst_mid_state", 32'(hz[1]), 0);
    chk("rst_mid_stall_cnt", scnt[1], 0);
    chk("rst_mid_flush_cnt", fcnt[1], 0);
    chk("rst_mid_release", 32'(sF[1]), 0);

    // 4-bit counter saturation under a held load-use hazard
    set_lu();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 13) chk("sat_cnt_14", 32'(scnt4), 14);
    end
    chk("sat_cnt_max", 32'(scnt4), 15);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
